multicycle_ctrl_fsm: RTL

//  Moore main controller for the multicycle RV32I core. Sequences the shared ALU, instruction

---
 rtl/multicycle_ctrl_fsm.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_fsm
//   Main controller for the multicycle RV32I core. It sequences the shared ALU,
//   the instruction register, the PC and the unified memory through the
//   FETCH..WRITEBACK states. It stalls on the memory-ready handshake, traps
//   unsupported opcodes and counts retired instructions.
//
// Ports
//   clk        core clock, rising edge
//   reset      synchronous, active-high
//   op         opcode field instr[6:0]
//   Zero       ALU zero flag, used in BEQ
//   MemReady   memory completes the current access this cycle
//   PCWrite    PC load enable (gated by MemReady in FETCH, by Zero in BEQ)
//   AdrSrc     0: address=PC, 1: address=ALUOut
//   MemWrite   memory write request, held until MemReady
//   IRWrite    IR / OldPC load enable (gated by MemReady in FETCH)
//   ResultSrc  00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA    00 PC, 01 OldPC, 10 rs1
//   ALUSrcB    00 rs2, 01 ImmExt, 10 constant 4
//   ALUOp      00 ADD, 01 SUB, 10 funct-decoded
//   RegWrite   register file write enable
//   Illegal    sticky unsupported-opcode flag
//   State      current state encoding (debug)
//   InstRet    retired-instruction count, wraps silently
// ----------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             RegWrite,
    output logic             Illegal,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] InstRet
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

    // Moore part of the control word. PC/IR enables are kept as qualifiers
    // here and combined with MemReady/Zero at the output.
    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic       reg_write;
        logic       pc_always;   // unconditional PC load (JAL)
        logic       pc_zero;     // PC load when Zero (BEQ)
        logic       fetch;       // PC/IR load when MemReady (FETCH)
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic ctrl_t decode(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.fetch      = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            S_MEMREAD:  c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
            S_EXECI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
            S_ALUWB:    c.reg_write = 1'b1;
            S_JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.pc_always = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b01;
                c.pc_zero   = 1'b1;
            end
            default: c = '0;     // TRAP and unreachable codes: everything off
        endcase
        return c;
    endfunction

    state_e     state_q, state_d;
    ctrl_t      ctrl_q;
    logic       illegal_q;
    logic [CNT_W-1:0] instret_q;
    logic       retire;

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:    if (MemReady) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BEQ:            state_d = S_BEQ;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
            S_MEMWRITE: begin
                if (MemReady) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BEQ: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default:    state_d = S_TRAP;
        endcase
    end

    // Control word is registered from the next state so it lines up with
    // state_q without a decode stage on the output path.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            ctrl_q    <= decode(S_FETCH);
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= decode(state_d);
            illegal_q <= illegal_q | (state_d == S_TRAP);
            if (retire) instret_q <= instret_q + CNT_W'(1);
        end
    end

    // Gating PC/IR with MemReady gives exactly one PC increment per fetch no
    // matter how long the fetch stalls. Enables are killed while in reset.
    assign IRWrite   = ~reset & ctrl_q.fetch & MemReady;
    assign PCWrite   = ~reset & ((ctrl_q.fetch & MemReady) |
                                 (ctrl_q.pc_zero & Zero) |
                                  ctrl_q.pc_always);
    assign MemWrite  = ~reset & ctrl_q.mem_write;
    assign RegWrite  = ~reset & ctrl_q.reg_write;
    assign AdrSrc    = ctrl_q.adr_src;
    assign ResultSrc = ctrl_q.result_src;
    assign ALUSrcA   = ctrl_q.alu_src_a;
    assign ALUSrcB   = ctrl_q.alu_src_b;
    assign ALUOp     = ctrl_q.alu_op;
    assign Illegal   = illegal_q;
    assign State     = state_q;
    assign InstRet   = instret_q;

endmodule
